// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the fetch port, the data port, the shared
// memory port and the status outputs. The arbiter uses the master modport.
// That modport drives the shared memory, the completion signals and the
// status outputs. The slave modport is the mirror view for the cores and
// memory around the arbiter.
interface mem_arbiter_if;
    // fetch port
    logic        inst_req_F;
    logic [31:0] inst_addr_F;
    logic [31:0] inst_rdata_F;
    logic        inst_mem_ack_F;
    // data port
    logic        data_req_M;
    logic        data_we_M;
    logic [31:0] data_addr_M;
    logic [31:0] data_wdata_M;
    logic [31:0] data_rdata_M;
    logic        data_mem_ack_M;
    // shared memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // status
    logic        stall_mem;
    logic        grant_data;

    modport master (
        input  inst_req_F, inst_addr_F,
        output inst_rdata_F, inst_mem_ack_F,
        input  data_req_M, data_we_M, data_addr_M, data_wdata_M,
        output data_rdata_M, data_mem_ack_M,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output stall_mem, grant_data
    );

    modport slave (
        output inst_req_F, inst_addr_F,
        input  inst_rdata_F, inst_mem_ack_F,
        output data_req_M, data_we_M, data_addr_M, data_wdata_M,
        input  data_rdata_M, data_mem_ack_M,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  stall_mem, grant_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// port and a data port. Data normally wins over fetch.
// Optional feature: define MEM_ARB_FAIR_EN to compile in a starvation
// counter. With it, the waiting fetch is granted after STARVE_LIMIT
// consecutive data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.master bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

    state_t      state;
    state_t      state_next;
    logic        take_inst;
    logic        take_data;
    logic        inst_ok;
    logic        data_ok;
    logic        fetch_first;

    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] inst_rdata_r;
    logic [31:0] data_rdata_r;
    logic        inst_ack_r;
    logic        data_ack_r;

    // A port whose ack is high this cycle already got its answer; its
    // still-high req belongs to the finished transaction.
    assign inst_ok = bus.inst_req_F & ~inst_ack_r;
    assign data_ok = bus.data_req_M & ~data_ack_r;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    // Count data grants made while a fetch waits; any fetch grant or idle fetch port clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (!bus.inst_req_F || take_inst) begin
            starve_cnt <= 4'd0;
        end else if (take_data && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign fetch_first = (starve_cnt == LIMIT) & inst_ok & bus.data_req_M;
`else
    assign fetch_first = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration and next state. A data req that is still high, even in
    // its own ack cycle, keeps the fetch waiting. This gives strict data
    // priority; only the starvation counter can override it.
    always_comb begin
        state_next = state;
        take_inst  = 1'b0;
        take_data  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_first) begin
                    take_inst = 1'b1;
                end else if (bus.data_req_M) begin
                    take_data = data_ok;
                end else begin
                    take_inst = inst_ok;
                end
                if (take_inst) begin
                    state_next = INST;
                end else if (take_data) begin
                    state_next = DATA;
                end
            end
            INST, DATA: begin
                if (bus.mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's request on the grant edge; it holds until the next grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else if (take_data) begin
            mem_we_r    <= bus.data_we_M;
            mem_addr_r  <= bus.data_addr_M;
            mem_wdata_r <= bus.data_wdata_M;
        end else if (take_inst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= bus.inst_addr_F;
            mem_wdata_r <= 32'd0;
        end
    end

    // Completion: capture read data for the owner and pulse its ack for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_rdata_r <= 32'd0;
            data_rdata_r <= 32'd0;
            inst_ack_r   <= 1'b0;
            data_ack_r   <= 1'b0;
        end else begin
            inst_ack_r <= (state == INST) & bus.mem_ack;
            data_ack_r <= (state == DATA) & bus.mem_ack;
            if (state == INST && bus.mem_ack) begin
                inst_rdata_r <= bus.mem_rdata;
            end
            if (state == DATA && bus.mem_ack) begin
                data_rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req        = (state == INST) | (state == DATA);
    assign bus.mem_we         = mem_we_r;
    assign bus.mem_addr       = mem_addr_r;
    assign bus.mem_wdata      = mem_wdata_r;
    assign bus.inst_rdata_F   = inst_rdata_r;
    assign bus.inst_mem_ack_F = inst_ack_r;
    assign bus.data_rdata_M   = data_rdata_r;
    assign bus.data_mem_ack_M = data_ack_r;
    assign bus.grant_data     = (state == DATA);
    assign bus.stall_mem      = (bus.inst_req_F & ~inst_ack_r) | (bus.data_req_M & ~data_ack_r);

endmodule
